uart_rx_os: RTL

- Next-generation UART receiver. Parametrised in data width, parity, stop bits and oversampling.
- Samples each bit at its centre using an oversampled tick and checks parity and stop bits.
- Presents each received word through a ready/valid holding register with error flags.
- Sits between the pad-side rx line and the consumer logic (FIFO or CSR block) in the UART subsystem.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_baud_tick.sv | 20 ++
 rtl/uart_rx_os.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and baud divisor helper for the UART subsystem.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_mode_e;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;

    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-clk tick every DIV clks.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk)
        if (rst || tick) cnt <= '0;
        else cnt <= cnt + W'(1);

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with parity/stop checks and a ready/valid output register.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 1000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = 4;
    localparam parity_mode_e PM = parity_mode_e'(2'(PARITY_MODE));

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_os: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end

    logic rx_m, rx_s, tick, bit_v, centre, done;
    rx_state_e state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic ferr, ferr_n, perr, perr_n;

    always_ff @(posedge clk)
        if (rst) {rx_m, rx_s} <= 2'b11;
        else {rx_m, rx_s} <= {rx, rx_m};

    uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAG = 1;
    logic [1:0] hist;
    always_ff @(posedge clk)
        if (rst) hist <= 2'b11;
        else if (tick) hist <= {hist[0], rx_s};
    // decision at centre+1: hist holds centre-1 and centre, rx_s is centre+1
    assign bit_v = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    localparam int LAG = 0;
    assign bit_v = rx_s;
`endif

    localparam int START_T = OVERSAMPLE / 2 - 1 + LAG;

    assign centre = tick && tcnt == TW'(OVERSAMPLE - 1);

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            sh    <= '0;
            ferr  <= 1'b0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            bcnt  <= bcnt_n;
            sh    <= sh_n;
            ferr  <= ferr_n;
            perr  <= perr_n;
        end

    always_comb begin
        state_n = state;
        tcnt_n  = tick ? tcnt + TW'(1) : tcnt;
        bcnt_n  = bcnt;
        sh_n    = sh;
        ferr_n  = ferr;
        perr_n  = perr;
        done    = 1'b0;
        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (tick && !rx_s) state_n = START;
            end
            START: if (tick && tcnt == TW'(START_T)) begin
                state_n = bit_v ? IDLE : DATA;
                tcnt_n  = '0;
                bcnt_n  = '0;
                ferr_n  = 1'b0;
                perr_n  = 1'b0;
            end
            DATA: if (centre) begin
                sh_n   = {bit_v, sh[DATA_BITS-1:1]};
                tcnt_n = '0;
                bcnt_n = bcnt + BW'(1);
                if (bcnt == BW'(DATA_BITS - 1)) begin
                    state_n = PM == PAR_NONE ? STOP : PARITY;
                    bcnt_n  = '0;
                end
            end
            PARITY: if (centre) begin
                perr_n  = (^sh ^ bit_v) != (PM == PAR_ODD);
                state_n = STOP;
                tcnt_n  = '0;
            end
            STOP: if (centre) begin
                ferr_n = ferr | !bit_v;
                tcnt_n = '0;
                bcnt_n = bcnt + BW'(1);
                if (bcnt == BW'(STOP_BITS - 1)) begin
                    done    = 1'b1;
                    state_n = bit_v ? IDLE : BREAK;
                end
            end
            BREAK: begin
                tcnt_n = '0;
                if (tick && rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // a word completing on the handshake clk replaces the accepted one
    always_ff @(posedge clk)
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= done && rx_valid && !rx_ready;
            if (done && (!rx_valid || rx_ready)) begin
                rx_data    <= sh;
                frame_err  <= ferr_n;
                parity_err <= perr;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
        end

endmodule
